// File: rtl/hilo_mdu_pkg.sv
// Shared opcodes, FSM encoding and helpers for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

  localparam logic [4:0] ALU_DONOTHING = 5'd0;
  localparam logic [4:0] ALU_ADD       = 5'd1;
  localparam logic [4:0] ALU_MULT      = 5'd10;
  localparam logic [4:0] ALU_MULTU     = 5'd11;
  localparam logic [4:0] ALU_DIV       = 5'd12;
  localparam logic [4:0] ALU_DIVU      = 5'd13;
  localparam logic [4:0] ALU_MFHI      = 5'd14;
  localparam logic [4:0] ALU_MFLO      = 5'd15;
  localparam logic [4:0] ALU_MTHI      = 5'd16;
  localparam logic [4:0] ALU_MTLO      = 5'd17;
  localparam logic [4:0] ALU_ZERO      = 5'd31;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  function automatic logic is_mul_op(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] code);
    return (code == ALU_MULT) || (code == ALU_DIV);
  endfunction

endpackage

// File: rtl/hilo_mdu_div_radix2.sv
// Unsigned restoring divider, one quotient bit per cycle. The quot/rem outputs
// present the result of the iteration in progress, so done marks the final step.
module div_radix2
  import hilo_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] rem_q, quot_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        run_q;
  logic [32:0] rem_sh;
  logic        qbit;

  assign rem_sh = {rem_q, quot_q[31]};
  assign qbit   = rem_sh >= {1'b0, dvs_q};
  assign rem    = qbit ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
  assign quot   = {quot_q[30:0], qbit};
  assign done   = run_q & (cnt_q == 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (abort) begin
      run_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= 5'(DIV_ITERS - 1);
      run_q  <= 1'b1;
    end else if (run_q) begin
      rem_q  <= rem;
      quot_q <= quot;
      cnt_q  <= cnt_q - 5'd1;
      if (cnt_q == 5'd0) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO owner in EX: multi-cycle MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO,
// stalling the pipeline through busy_o while an operation is in flight.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int MUL_LATENCY = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alucontrol,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q, hi, lo;
  logic        sgn_q;

  logic        issue, sgn_in;
  logic [31:0] abs_a, abs_b;
  logic        div_start, div_abort, div_done;
  logic [31:0] quot_u, rem_u, quot_s, rem_s;
  logic        neg_q, neg_r;
  logic signed [63:0] prod;

  assign issue  = valid_i & ~flush_i & (is_mul_op(alucontrol) | is_div_op(alucontrol));
  assign sgn_in = is_signed_op(alucontrol);
  assign abs_a  = (sgn_in & a_i[31]) ? -a_i : a_i;
  assign abs_b  = (sgn_in & b_i[31]) ? -b_i : b_i;

  // Divider takes magnitudes straight from the issue cycle; signs are fixed up on write-back.
  assign div_start = (state == ST_IDLE) & issue & is_div_op(alucontrol);
  assign div_abort = (state == ST_DIV) & flush_i;

  div_radix2 u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done     (div_done),
    .quot     (quot_u),
    .rem      (rem_u)
  );

  assign prod = $signed({{32{sgn_q & a_q[31]}}, a_q}) * $signed({{32{sgn_q & b_q[31]}}, b_q});

  assign neg_q  = sgn_q & (a_q[31] ^ b_q[31]);
  assign neg_r  = sgn_q & a_q[31];
  assign quot_s = neg_q ? -quot_u : quot_u;
  assign rem_s  = neg_r ? -rem_u : rem_u;

  assign busy_o = ((state == ST_IDLE) & issue) |
                  (((state == ST_MUL) | (state == ST_DIV)) & ~flush_i);
  assign hi_o   = hi;
  assign lo_o   = lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            a_q   <= a_i;
            b_q   <= b_i;
            sgn_q <= sgn_in;
            if (is_mul_op(alucontrol)) begin
              state <= ST_MUL;
              cnt   <= 5'(MUL_LATENCY - 1);
            end else begin
              state <= ST_DIV;
              cnt   <= 5'(DIV_ITERS - 1);
            end
          end else if (valid_i & ~flush_i & ~stall_i) begin
            if (alucontrol == ALU_MTHI) hi <= a_i;
            if (alucontrol == ALU_MTLO) lo <= a_i;
          end
        end
        ST_MUL: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (cnt == 5'd0) begin
            {hi, lo} <= prod;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_DIV: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else if (div_done) begin
            // Divide by zero bypasses sign correction entirely.
            if (b_q == 32'd0) begin
              hi <= a_q;
              lo <= 32'hFFFF_FFFF;
            end else begin
              hi <= rem_s;
              lo <= quot_s;
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ST_DONE: begin
          if (flush_i | ~stall_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomised + directed bench for hilo_mdu against an arithmetic reference model.
module tb_hilo_mdu;
  import hilo_mdu_pkg::*;

  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alucontrol;
  logic        valid_i, flush_i, stall_i;
  logic [31:0] a_i, b_i;
  logic        busy_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  hilo_mdu #(.MUL_LATENCY(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .alucontrol (alucontrol),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .stall_i    (stall_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .busy_o     (busy_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit md(input logic [4:0] c);
    return c == ALU_MULT || c == ALU_MULTU || c == ALU_DIV || c == ALU_DIVU;
  endfunction

  // Reference result of a HI/LO arithmetic op from plain integer arithmetic.
  task automatic calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] h, output logic [31:0] l);
    int ia, ib;
    longint p;
    logic [63:0] pu;
    ia = a; ib = b;
    h = 0; l = 0;
    case (op)
      ALU_MULT:  begin p = longint'(ia) * longint'(ib); {h, l} = p; end
      ALU_MULTU: begin pu = {32'd0, a} * {32'd0, b}; {h, l} = pu; end
      ALU_DIV: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
        else begin l = ia / ib; h = ia % ib; end
      end
      ALU_DIVU: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endtask

  // Model: pending op counts down its MUL/DIV cycles, then waits for stall release.
  logic [31:0] m_hi = 0, m_lo = 0, r_hi = 0, r_lo = 0;
  int          m_left = 0;
  bit          m_done = 0;

  always @(posedge clk) begin : model
    logic [31:0] th, tl;
    if (rst) begin
      m_hi <= 0; m_lo <= 0; m_left <= 0; m_done <= 0;
    end else if (m_left > 0) begin
      if (flush_i) m_left <= 0;
      else if (m_left == 1) begin
        m_hi <= r_hi; m_lo <= r_lo; m_left <= 0; m_done <= 1;
      end else m_left <= m_left - 1;
    end else if (m_done) begin
      if (flush_i || !stall_i) m_done <= 0;
    end else if (valid_i && !flush_i) begin
      if (md(alucontrol)) begin
        calc(alucontrol, a_i, b_i, th, tl);
        r_hi <= th; r_lo <= tl;
        m_left <= (alucontrol == ALU_MULT || alucontrol == ALU_MULTU) ? ML : 32;
      end else if (!stall_i) begin
        if (alucontrol == ALU_MTHI) m_hi <= a_i;
        if (alucontrol == ALU_MTLO) m_lo <= a_i;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic eb;
    if (!rst) begin
      if (m_left > 0) eb = !flush_i;
      else if (m_done) eb = 1'b0;
      else eb = valid_i && !flush_i && md(alucontrol);
      chk("busy", {31'd0, busy_o}, {31'd0, eb});
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
    end
  end

  // Presents one EX instruction until it leaves EX; operands are scrambled after issue.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int nstall, input int flush_at, output int nbusy);
    int cyc;
    bit fl;
    cyc = 0; nbusy = 0;
    alucontrol = op; a_i = a; b_i = b; valid_i = 1'b1;
    stall_i = (nstall > 0); flush_i = 1'b0;
    forever begin
      flush_i = (cyc == flush_at);
      @(negedge clk);
      if (busy_o) nbusy++;
      if (flush_i || !busy_o) break;
      if (cyc >= 100) begin
        checks++; fails++;
        $display("FAIL timeout: busy_o still high after %0d cycles, expected low", cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      a_i = $urandom; b_i = $urandom;
    end
    fl = flush_i;
    @(posedge clk); #1;
    flush_i = 1'b0;
    if (!fl && md(op) && nstall > 0) begin
      repeat (nstall) begin @(posedge clk); #1; end
      stall_i = 1'b0;
      @(posedge clk); #1;
    end
    stall_i = 1'b0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    logic [4:0] ops [8];
    ops = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_ADD};
    rst = 1'b1; valid_i = 0; flush_i = 0; stall_i = 0;
    alucontrol = ALU_DONOTHING; a_i = 0; b_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi_o, 32'h0);
    chk("reset_lo", lo_o, 32'h0);
    chk("reset_busy", {31'd0, busy_o}, 32'h0);
    rst = 1'b0;

    do_op(ALU_DIVU, 32'd100, 32'd7, 0, -1, nb);
    chk("divu_busy_cycles", 32'(nb), 32'd33);
    chk("divu_lo", lo_o, 32'd14);
    chk("divu_hi", hi_o, 32'd2);

    do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, -1, nb);
    chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);

    do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, nb);
    chk("div_ovf_lo", lo_o, 32'h8000_0000);
    chk("div_ovf_hi", hi_o, 32'h0);

    do_op(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, nb);
    chk("mult_hi", hi_o, 32'h0);
    chk("mult_lo", lo_o, 32'h1);

    do_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, nb);
    chk("multu_busy_cycles", 32'(nb), 32'(ML + 1));
    chk("multu_hi", hi_o, 32'hFFFF_FFFE);
    chk("multu_lo", lo_o, 32'h1);

    do_op(ALU_DIV, 32'h1234, 32'h0, 0, -1, nb);
    chk("div0_busy_cycles", 32'(nb), 32'd33);
    chk("div0_lo", lo_o, 32'hFFFF_FFFF);
    chk("div0_hi", hi_o, 32'h1234);

    do_op(ALU_MTHI, 32'hAA, 32'h0, 0, -1, nb);
    chk("mthi_busy", 32'(nb), 32'd0);
    do_op(ALU_MTLO, 32'h55, 32'h0, 0, -1, nb);
    chk("mtlo_busy", 32'(nb), 32'd0);
    chk("mthi_hi", hi_o, 32'hAA);
    chk("mtlo_lo", lo_o, 32'h55);

    do_op(ALU_DIV, 32'd1000, 32'd3, 0, 10, nb);
    chk("flush10_hi", hi_o, 32'hAA);
    chk("flush10_lo", lo_o, 32'h55);
    do_op(ALU_DIV, 32'd1000, 32'd3, 0, 32, nb);
    chk("flushlast_hi", hi_o, 32'hAA);
    chk("flushlast_lo", lo_o, 32'h55);
    do_op(ALU_DIVU, 32'd100, 32'd7, 0, -1, nb);
    chk("after_flush_busy", 32'(nb), 32'd33);
    chk("after_flush_lo", lo_o, 32'd14);

    do_op(ALU_MULT, 32'd3, 32'd5, 5, -1, nb);
    chk("stall_busy_cycles", 32'(nb), 32'(ML + 1));
    chk("stall_lo", lo_o, 32'd15);
    chk("stall_hi", hi_o, 32'd0);

    for (int i = 0; i < 80; i++) begin
      int fa;
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 34)) : -1;
      do_op(ops[$urandom_range(0, 7)], rnd_opnd(), ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_opnd(),
            int'($urandom_range(0, 3)), fa, nb);
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 1'b0; alucontrol = ALU_ZERO;
        @(posedge clk); #1;
      end
    end

    do_op(ALU_MTHI, 32'h77, 32'h0, 0, -1, nb);
    alucontrol = ALU_DIV; a_i = 32'd1000; b_i = 32'd3; valid_i = 1'b1;
    repeat (10) begin @(posedge clk); #1; a_i = $urandom; end
    rst = 1'b1; valid_i = 1'b0; alucontrol = ALU_DONOTHING;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_hi", hi_o, 32'h0);
    chk("midrst_lo", lo_o, 32'h0);
    chk("midrst_busy", {31'd0, busy_o}, 32'h0);
    do_op(ALU_DIVU, 32'd100, 32'd7, 0, -1, nb);
    chk("post_rst_busy", 32'(nb), 32'd33);
    chk("post_rst_hi", hi_o, 32'd2);

    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
